// File: rtl/sram_like_if.sv
// sram_like_if -- one SRAM-like bus (cpu_axi_interface style).
//
// The requester side drives req/wr/size/addr/wdata and sees addr_ok/data_ok/rdata.
//   master : the requester view of the bus (drives the request fields)
//   slave  : the responder view of the bus (drives addr_ok/data_ok/rdata)
//
// Signals
//   req      1   request, held until addr_ok
//   wr       1   write flag
//   size     2   access size
//   addr     32  byte address
//   wdata    32  write data
//   addr_ok  1   address accepted (handshake when req && addr_ok)
//   data_ok  1   response valid, responses return in issue order
//   rdata    32  read data
interface sram_like_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter -- shares one SRAM-like master port between an instruction
// requester and a data requester.
//
// A grant is registered (one cycle of arbitration latency) and held until the
// address handshake. Every accepted request pushes its owner onto an in-order
// tag FIFO; each m_data_ok pops the head tag and is routed back to that owner.
//
// Parameters
//   MAX_OUTSTANDING  accepted-but-unanswered requests tracked (power of 2, >= 2)
//
// Ports
//   clk     clock
//   rstn    asynchronous reset, active low
//   i_bus   slave  : instruction requester
//   d_bus   slave  : data requester
//   m_bus   master : shared downstream port
//
// Configuration
//   SRAM_ARB_RR_EN  defined   : round-robin, priority flips after every handshake
//                   undefined : fixed priority, data wins ties
module sram_like_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input logic        clk,
  input logic        rstn,
  sram_like_if.slave  i_bus,
  sram_like_if.slave  d_bus,
  sram_like_if.master m_bus
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [PTR_W:0] FULL_CNT  = (PTR_W + 1)'(MAX_OUTSTANDING);
  localparam logic [PTR_W:0] LAST_SLOT = (PTR_W + 1)'(MAX_OUTSTANDING - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] head_reg, tail_reg;
  logic [PTR_W:0]   count_reg, count_next;
  // Owner tag per FIFO slot: 1 = data requester, 0 = instruction requester.
  logic             tag_reg [MAX_OUTSTANDING];

  logic push, push_tag, pop, head_tag, full;
  logic prio_d;   // 1: data wins a tie

  // Pick the next owner. Returning IDLE means nobody is asking.
  function automatic state_t pick_winner(input logic ireq, input logic dreq,
                                         input logic pd);
    state_t w;
    w = IDLE;
    if (ireq && dreq) w = pd ? GNT_D : GNT_I;
    else if (dreq)    w = GNT_D;
    else if (ireq)    w = GNT_I;
    return w;
  endfunction

`ifdef SRAM_ARB_RR_EN
  logic prio_reg, prio_next;

  // After a handshake the side that was just served loses priority.
  always_comb begin
    prio_next = prio_reg;
    if (push) prio_next = (state_reg == GNT_I);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) prio_reg <= 1'b1;
    else       prio_reg <= prio_next;
  end

  assign prio_d = prio_reg;
`else
  assign prio_d = 1'b1;
`endif

  assign full     = (count_reg == FULL_CNT);
  assign pop      = m_bus.data_ok && (count_reg != '0);
  assign head_tag = tag_reg[head_reg];

  // Responses are routed combinationally from the head tag. A data_ok with
  // nothing outstanding is a slave protocol error and is swallowed.
  assign i_bus.data_ok = pop && !head_tag;
  assign d_bus.data_ok = pop &&  head_tag;
  assign i_bus.rdata   = m_bus.rdata;
  assign d_bus.rdata   = m_bus.rdata;

  always_comb begin
    state_next    = state_reg;
    m_bus.req     = 1'b0;
    m_bus.wr      = 1'b0;
    m_bus.size    = 2'd0;
    m_bus.addr    = 32'd0;
    m_bus.wdata   = 32'd0;
    i_bus.addr_ok = 1'b0;
    d_bus.addr_ok = 1'b0;
    push          = 1'b0;
    push_tag      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!full) state_next = pick_winner(i_bus.req, d_bus.req, prio_d);
      end

      GNT_I: begin
        m_bus.req     = i_bus.req;
        m_bus.wr      = i_bus.wr;
        m_bus.size    = i_bus.size;
        m_bus.addr    = i_bus.addr;
        m_bus.wdata   = i_bus.wdata;
        push          = i_bus.req && m_bus.addr_ok;
        push_tag      = 1'b0;
        i_bus.addr_ok = push;
        // The owner's req in the handshake cycle belongs to the request being
        // accepted, so only the other side can claim the back-to-back slot.
        // The decision ignores a same-cycle pop: freed space is used next cycle.
        if (push) begin
          state_next = (count_reg == LAST_SLOT) ? IDLE
                                                : pick_winner(1'b0, d_bus.req, prio_d);
        end
      end

      GNT_D: begin
        m_bus.req     = d_bus.req;
        m_bus.wr      = d_bus.wr;
        m_bus.size    = d_bus.size;
        m_bus.addr    = d_bus.addr;
        m_bus.wdata   = d_bus.wdata;
        push          = d_bus.req && m_bus.addr_ok;
        push_tag      = 1'b1;
        d_bus.addr_ok = push;
        if (push) begin
          state_next = (count_reg == LAST_SLOT) ? IDLE
                                                : pick_winner(i_bus.req, 1'b0, prio_d);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
    end
  end

  // Tag storage is read combinationally from the head, so it lives in flops.
  generate
    for (genvar gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                                   tag_reg[gi] <= 1'b0;
        else if (push && (tail_reg == PTR_W'(gi)))   tag_reg[gi] <= push_tag;
      end
    end
  endgenerate

endmodule
